// File: rtl/led_decoder_seq_pkg.sv
// led_pkg: constants shared by the LED sequencer slice.
//   mode_e : display mode encoding (static, chase, bounce, blink)
//   DIR_UP / DIR_DN : bounce sweep direction
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_CHASE  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_decoder_seq_if.sv
// led_decoder_seq_if: control/status bundle of the LED sequencer.
//   en, mode, sel, div : driven by the controller (master)
//   led, pos, tick     : driven by the sequencer (slave)
interface led_decoder_seq_if #(
  parameter int SEL_W = 3,
  parameter int N_LED = 8,
  parameter int DIV_W = 24
);

  logic             en;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic [DIV_W-1:0] div;
  logic [N_LED-1:0] led;
  logic [SEL_W-1:0] pos;
  logic             tick;

  modport master (
    output en, mode, sel, div,
    input  led, pos, tick
  );

  modport slave (
    input  en, mode, sel, div,
    output led, pos, tick
  );

endinterface

// File: rtl/led_decoder_seq_tick_div.sv
// tick_div: programmable tick divider.
//   clk, rst : clock and synchronous active-high reset
//   en       : count enable; 0 holds the counter and blocks tick
//   clr      : restart the period (counter to 0, tick blocked)
//   div      : period minus 1 in clk cycles
//   tick     : combinational strobe, high while the period completes
module tick_div #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;
  logic             hit_s;

  assign hit_s = (cnt_r == div);
  // clr and rst both veto the strobe so a restart never also advances a pattern.
  assign tick  = en && hit_s && !clr && !rst;

  // Period counter; a div lowered below cnt simply counts up and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (hit_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + DIV_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/led_decoder_seq.sv
// led_decoder_seq: binary select to registered one-hot LED vector with
// timed chase, bounce and blink modes.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of led_decoder_seq_if
//              in : en (tick enable), mode, sel (LED index), div (period-1)
//              out: led (registered), pos (lit index), tick (divider strobe)
module led_decoder_seq
  import led_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int N_LED = 8,
  parameter int DIV_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  led_decoder_seq_if.slave    bus
);

  localparam logic [SEL_W-1:0] LAST_POS = SEL_W'(N_LED - 1);
  localparam logic [SEL_W-1:0] PREV_POS = SEL_W'(N_LED - 2);
  localparam logic [SEL_W:0]   N_LED_W  = (SEL_W + 1)'(N_LED);

  // Indices at or above N_LED decode to an all-dark vector.
  function automatic logic [N_LED-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_LED-1:0] vec;
    vec = '0;
    for (int i = 0; i < N_LED; i++) begin
      if (idx == SEL_W'(i)) begin
        vec[i] = 1'b1;
      end else begin
        vec[i] = 1'b0;
      end
    end
    return vec;
  endfunction

  mode_e            mode_q_r;
  logic [SEL_W-1:0] pos_r;
  logic             dir_r;
  logic             phase_r;
  logic [N_LED-1:0] led_r;

  logic             mode_chg_s;
  logic             tick_s;
  logic             dir_base_s;
  logic             phase_base_s;
  logic             pos_oor_s;
  logic [SEL_W-1:0] pos_n_s;
  logic             dir_n_s;
  logic             phase_n_s;
  logic [N_LED-1:0] led_n_s;

  assign mode_chg_s = (bus.mode != mode_q_r);
  // Widened compare so the check stays meaningful when N_LED == 2**SEL_W.
  assign pos_oor_s  = ({1'b0, pos_r} >= N_LED_W);

  tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (mode_chg_s),
    .div  (bus.div),
    .tick (tick_s)
  );

  // Next-state pattern logic; a mode change restarts dir/phase but keeps pos.
  always_comb begin
    dir_base_s   = mode_chg_s ? DIR_UP : dir_r;
    phase_base_s = mode_chg_s ? 1'b1 : phase_r;
    pos_n_s      = pos_r;
    dir_n_s      = dir_base_s;
    phase_n_s    = phase_base_s;
    led_n_s      = led_r;
    case (bus.mode)
      MODE_STATIC: begin
        pos_n_s = bus.sel;
        led_n_s = onehot(bus.sel);
      end
      MODE_CHASE: begin
        if (tick_s) begin
          pos_n_s = (pos_r == LAST_POS) ? '0 : pos_r + SEL_W'(1);
        end else begin
          pos_n_s = pos_r;
        end
        led_n_s = onehot(pos_n_s);
      end
      MODE_BOUNCE: begin
        if (!tick_s) begin
          pos_n_s = pos_r;
        end else if (pos_oor_s) begin
          pos_n_s = '0;
        end else if (dir_r == DIR_UP) begin
          if (pos_r == LAST_POS) begin
            dir_n_s = DIR_DN;
            pos_n_s = PREV_POS;
          end else begin
            pos_n_s = pos_r + SEL_W'(1);
          end
        end else begin
          if (pos_r == '0) begin
            dir_n_s = DIR_UP;
            pos_n_s = SEL_W'(1);
          end else begin
            pos_n_s = pos_r - SEL_W'(1);
          end
        end
        led_n_s = onehot(pos_n_s);
      end
      MODE_BLINK: begin
        pos_n_s = bus.sel;
        if (tick_s) begin
          phase_n_s = ~phase_r;
        end else begin
          phase_n_s = phase_base_s;
        end
        led_n_s = phase_n_s ? onehot(bus.sel) : '0;
      end
      default: begin
        pos_n_s = bus.sel;
        led_n_s = onehot(bus.sel);
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q_r <= MODE_STATIC;
      pos_r    <= '0;
      dir_r    <= DIR_UP;
      phase_r  <= 1'b1;
      led_r    <= '0;
    end else begin
      mode_q_r <= mode_e'(bus.mode);
      pos_r    <= pos_n_s;
      dir_r    <= dir_n_s;
      phase_r  <= phase_n_s;
      led_r    <= led_n_s;
    end
  end

  assign bus.led  = led_r;
  assign bus.pos  = pos_r;
  assign bus.tick = tick_s;

endmodule

// File: tb/tb_led_decoder_seq.sv
// Self-checking bench for led_decoder_seq (8-LED and 6-LED instances).
module tb_led_decoder_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  led_decoder_seq_if #(.SEL_W(3), .N_LED(8), .DIV_W(24)) bus8 ();
  led_decoder_seq_if #(.SEL_W(3), .N_LED(6), .DIV_W(24)) bus6 ();

  led_decoder_seq #(.SEL_W(3), .N_LED(8), .DIV_W(24)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  led_decoder_seq #(.SEL_W(3), .N_LED(6), .DIV_W(24)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] led8;
    logic [5:0] led6;
  } static_vec_t;

  typedef struct {
    logic [2:0] pos;
    logic [7:0] led;
  } seq_vec_t;

  static_vec_t stat_tab [8];
  seq_vec_t    bounce_tab [15];
  logic [7:0]  chase_tab [8];
  logic [7:0]  blink_tab [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    stat_tab[0] = '{3'd0, 8'h01, 6'h01};
    stat_tab[1] = '{3'd1, 8'h02, 6'h02};
    stat_tab[2] = '{3'd2, 8'h04, 6'h04};
    stat_tab[3] = '{3'd3, 8'h08, 6'h08};
    stat_tab[4] = '{3'd4, 8'h10, 6'h10};
    stat_tab[5] = '{3'd5, 8'h20, 6'h20};
    stat_tab[6] = '{3'd6, 8'h40, 6'h00};
    stat_tab[7] = '{3'd7, 8'h80, 6'h00};

    chase_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

    bounce_tab[0]  = '{3'd1, 8'h02};
    bounce_tab[1]  = '{3'd2, 8'h04};
    bounce_tab[2]  = '{3'd3, 8'h08};
    bounce_tab[3]  = '{3'd4, 8'h10};
    bounce_tab[4]  = '{3'd5, 8'h20};
    bounce_tab[5]  = '{3'd6, 8'h40};
    bounce_tab[6]  = '{3'd7, 8'h80};
    bounce_tab[7]  = '{3'd6, 8'h40};
    bounce_tab[8]  = '{3'd5, 8'h20};
    bounce_tab[9]  = '{3'd4, 8'h10};
    bounce_tab[10] = '{3'd3, 8'h08};
    bounce_tab[11] = '{3'd2, 8'h04};
    bounce_tab[12] = '{3'd1, 8'h02};
    bounce_tab[13] = '{3'd0, 8'h01};
    bounce_tab[14] = '{3'd1, 8'h02};

    // sel=3, div=1: change edge lit, then two dark / two lit alternating
    blink_tab = '{8'h08, 8'h08, 8'h00, 8'h00, 8'h08, 8'h08, 8'h00, 8'h00};

    // ---------------- reset ----------------
    rst       = 1'b1;
    bus8.en   = 1'b0;
    bus8.mode = 2'b00;
    bus8.sel  = 3'd0;
    bus8.div  = 24'd0;
    bus6.en   = 1'b0;
    bus6.mode = 2'b00;
    bus6.sel  = 3'd0;
    bus6.div  = 24'd0;
    step();
    step();
    check("reset_led8", 32'(bus8.led), 32'h0);
    check("reset_pos8", 32'(bus8.pos), 32'h0);
    check("reset_tick8", 32'(bus8.tick), 32'h0);
    check("reset_led6", 32'(bus6.led), 32'h0);
    rst     = 1'b0;
    bus8.en = 1'b1;

    // ---------------- mode 00 static table ----------------
    for (int i = 0; i < 8; i++) begin
      bus8.sel = stat_tab[i].sel;
      bus6.sel = stat_tab[i].sel;
      #1;
      if (i > 0) begin
        check("static_latency", 32'(bus8.led), 32'(stat_tab[i-1].led8));
      end
      step();
      check("static_led8", 32'(bus8.led), 32'(stat_tab[i].led8));
      check("static_pos8", 32'(bus8.pos), 32'(stat_tab[i].sel));
      check("static_led6", 32'(bus6.led), 32'(stat_tab[i].led6));
    end

    // ---------------- mode 01 chase, div=2 ----------------
    bus8.sel = 3'd0;
    step();
    check("chase_prep_pos", 32'(bus8.pos), 32'h0);
    bus8.mode = 2'b01;
    bus8.div  = 24'd2;
    step();
    check("chase_entry_led", 32'(bus8.led), 32'h01);
    for (int k = 0; k < 8; k++) begin
      step();
      check("chase_notick", 32'(bus8.tick), 32'h0);
      step();
      check("chase_tick", 32'(bus8.tick), 32'h1);
      check("chase_hold", 32'(bus8.led), 32'(k == 0 ? 8'h01 : chase_tab[k-1]));
      step();
      check("chase_led", 32'(bus8.led), 32'(chase_tab[k]));
    end

    // ---------------- en=0 freeze ----------------
    step();
    bus8.en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("freeze_led", 32'(bus8.led), 32'h01);
      check("freeze_tick", 32'(bus8.tick), 32'h0);
    end
    bus8.en = 1'b1;
    #1;
    check("thaw_notick", 32'(bus8.tick), 32'h0);
    step();
    check("thaw_tick", 32'(bus8.tick), 32'h1);
    step();
    check("thaw_led", 32'(bus8.led), 32'h02);

    // ---------------- mode change 01->10 with pending tick ----------------
    bus8.div = 24'd1;
    step();
    check("pending_tick", 32'(bus8.tick), 32'h1);
    bus8.mode = 2'b10;
    #1;
    check("chg_tick_suppressed", 32'(bus8.tick), 32'h0);
    step();
    check("chg_pos_kept", 32'(bus8.pos), 32'h1);
    check("chg_led", 32'(bus8.led), 32'h02);
    check("chg_cnt_cleared", 32'(bus8.tick), 32'h0);
    step();
    check("chg_first_tick", 32'(bus8.tick), 32'h1);
    step();
    check("chg_dir_up_led", 32'(bus8.led), 32'h04);

    // ---------------- mode 10 bounce, div=0, from pos 0 ----------------
    bus8.mode = 2'b00;
    bus8.sel  = 3'd0;
    step();
    bus8.mode = 2'b10;
    bus8.div  = 24'd0;
    step();
    check("bounce_entry_pos", 32'(bus8.pos), 32'h0);
    check("bounce_entry_led", 32'(bus8.led), 32'h01);
    for (int k = 0; k < 15; k++) begin
      step();
      check("bounce_pos", 32'(bus8.pos), 32'(bounce_tab[k].pos));
      check("bounce_led", 32'(bus8.led), 32'(bounce_tab[k].led));
    end
    // from pos 1 going up: 2..7 then 6, leaving dir=down
    for (int k = 0; k < 7; k++) begin
      step();
    end
    check("bounce_down_pos", 32'(bus8.pos), 32'h6);

    // ---------------- reset mid-bounce ----------------
    rst = 1'b1;
    step();
    check("midrst_led", 32'(bus8.led), 32'h0);
    check("midrst_pos", 32'(bus8.pos), 32'h0);
    check("midrst_tick", 32'(bus8.tick), 32'h0);
    rst = 1'b0;
    step();
    check("postrst_led", 32'(bus8.led), 32'h01);
    step();
    check("postrst_first_tick", 32'(bus8.led), 32'h02);
    step();
    check("postrst_dir_up", 32'(bus8.led), 32'h04);

    // ---------------- mode 11 blink, sel=3, div=1 ----------------
    bus8.mode = 2'b11;
    bus8.sel  = 3'd3;
    bus8.div  = 24'd1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("blink_led", 32'(bus8.led), 32'(blink_tab[k]));
      check("blink_pos", 32'(bus8.pos), 32'h3);
    end
    bus8.sel = 3'd5;
    step();
    check("blink_sel5_lit", 32'(bus8.led), 32'h20);
    check("blink_sel5_pos", 32'(bus8.pos), 32'h5);
    step();
    check("blink_sel5_hold", 32'(bus8.led), 32'h20);
    step();
    check("blink_sel5_dark", 32'(bus8.led), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
